// File: rtl/convert_pos_to_neg.sv
// convert_pos_to_neg
//
// Converts a sign bit plus an unsigned magnitude into a WIDTH-bit
// two's-complement value. The conversion is bit-serial and LSB first. For
// negative inputs each bit is inverted and a carry-in of 1 is added, with the
// carry moving up one bit per clock.
//
// Protocol and timing:
//   - A start pulse in IDLE latches sign and mag.
//   - WIDTH clocks later the result and overflow flag are committed.
//   - done pulses for one cycle when the result is committed.
//   - start is ignored while busy; requests are not queued.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous, active-high reset
//   start   in   request pulse, sampled only in IDLE
//   sign    in   1 = negative value, sampled with start
//   mag     in   [WIDTH-1:0] unsigned magnitude, sampled with start
//   busy    out  high while a conversion is in progress (CONV or FIN)
//   result  out  [WIDTH-1:0] two's-complement result, held until next commit
//   done    out  one-cycle pulse; result and ovf are valid
//   ovf     out  value not representable in WIDTH-bit two's complement
//
// Build option:
//   CONV_SAT_EN  When defined, an overflowing result is replaced by the
//                nearest representable value: 2^(W-1)-1 for positive inputs
//                and -2^(W-1) for negative inputs. ovf is still asserted.
//                When undefined, the raw wrapped value is returned.

module convert_pos_to_neg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] mag,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             ovf
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic             s_q,       s_d;
    logic [WIDTH-1:0] m_q,       m_d;
    logic [WIDTH-1:0] sr_q,      sr_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             carry_q,   carry_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             ovf_q,     ovf_d;

    logic             m_bit;
    logic             out_bit;
    logic             ovf_calc;

    // Overflow depends only on the latched operands.
    // Positive: any value with the MSB set is too large.
    // Negative: only exactly 2^(W-1) fits among values with the MSB set.
    always_comb begin
        ovf_calc = 1'b0;
        if (!s_q) begin
            ovf_calc = m_q[WIDTH-1];
        end else begin
            ovf_calc = m_q[WIDTH-1] & (|m_q[WIDTH-2:0]);
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        m_d       = m_q;
        sr_d      = sr_q;
        bit_idx_d = bit_idx_q;
        carry_d   = carry_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        m_bit     = m_q[bit_idx_q];
        out_bit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d       = sign;
                    m_d       = mag;
                    carry_d   = 1'b1;
                    bit_idx_d = '0;
                    sr_d      = '0;
                    state_d   = CONV;
                end
            end

            CONV: begin
                if (s_q) begin
                    // ~m + 1, one bit at a time. The carry only survives
                    // through low-order zero bits of the magnitude.
                    out_bit = ~m_bit ^ carry_q;
                    carry_d = ~m_bit & carry_q;
                end else begin
                    out_bit = m_bit;
                end

                // Fill from the top so that after WIDTH shifts the first
                // bit processed has reached bit 0.
                sr_d      = {out_bit, sr_q[WIDTH-1:1]};
                bit_idx_d = bit_idx_q + IDX_W'(1);

                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    state_d   = FIN;
                    ovf_d     = ovf_calc;
`ifdef CONV_SAT_EN
                    if (ovf_calc) begin
                        result_d = s_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        result_d = sr_d;
                    end
`else
                    result_d = sr_d;
`endif
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= 1'b0;
            m_q       <= '0;
            sr_q      <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            m_q       <= m_d;
            sr_q      <= sr_d;
            bit_idx_q <= bit_idx_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
